// File: rtl/clock_pkg.sv
// Shared constants and types for the time/date keeper: FSM states, field codes,
// reset values and per-field limits.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_LO  = 2'b01,
    ST_SET_MID = 2'b10,
    ST_SET_HI  = 2'b11
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_LO   = 2'b01;
  localparam logic [1:0] FIELD_MID  = 2'b10;
  localparam logic [1:0] FIELD_HI   = 2'b11;

  localparam logic [13:0] YEAR_RST  = 14'd2000;
  localparam logic [4:0]  DAY_RST   = 5'd1;
  localparam logic [3:0]  MONTH_RST = 4'd1;
  localparam logic [13:0] MAX_YEAR  = 14'd9999;

  localparam logic [5:0] MAX_SEC   = 6'd59;
  localparam logic [5:0] MAX_MIN   = 6'd59;
  localparam logic [4:0] MAX_HOUR  = 5'd23;
  localparam logic [3:0] MAX_MONTH = 4'd12;

endpackage

// File: rtl/days_in_month.sv
// Combinational month length. The Gregorian leap rule is only built when
// TIME_DATE_LEAP_YEAR_EN is defined; otherwise February is fixed at 28 days.
module days_in_month (
  input  logic [3:0]  month,
  input  logic [13:0] yyyy,
  output logic [4:0]  days
);

  logic [4:0] feb_days;

`ifdef TIME_DATE_LEAP_YEAR_EN
  logic leap;
  assign leap = (yyyy[1:0] == 2'd0) &&
                (((yyyy % 14'd100) != 14'd0) || ((yyyy % 14'd400) == 14'd0));
  assign feb_days = leap ? 5'd29 : 5'd28;
`else
  logic unused_yyyy;
  assign unused_yyyy = ^yyyy;
  assign feb_days    = 5'd28;
`endif

  always_comb begin
    days = 5'd31;
    case (month)
      4'd2:                      days = feb_days;
      4'd4, 4'd6, 4'd9, 4'd11:   days = 5'd30;
      default:                   days = 5'd31;
    endcase
  end

endmodule

// File: rtl/time_date_keeper.sv
// Running time/date keeper with button-driven set mode and 2 Hz blink.
// Leap-year support is enabled by defining TIME_DATE_LEAP_YEAR_EN.
module time_date_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_set,
  input  logic        btn_inc,
  output logic [5:0]  ss,
  output logic [5:0]  mm,
  output logic [4:0]  hh,
  output logic [4:0]  dd,
  output logic [3:0]  month,
  output logic [13:0] yyyy,
  output logic        blink2Hz,
  output logic        set_mode,
  output logic [1:0]  field_sel,
  output logic        display_sel,
  output logic        mode
);

  localparam int SEC_W   = $clog2(CLK_HZ);
  localparam int BLINK_W = $clog2(CLK_HZ / 4 + 1);
  localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(CLK_HZ - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(CLK_HZ / 4 - 1);

  state_e             state_q, state_d;
  logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               dsel_q, dsel_d;
  logic [5:0]         ss_q, ss_d, mm_q, mm_d;
  logic [4:0]         hh_q, hh_d, dd_q, dd_d;
  logic [3:0]         month_q, month_d;
  logic [13:0]        yyyy_q, yyyy_d;

  logic        tick;
  logic [4:0]  run_days, clamp_days, next_dd, clamped_dd;
  logic [3:0]  inc_month, clamp_month;
  logic [13:0] inc_year, clamp_year;

  // One instance serves the running date, the other judges the would-be
  // month/year of a set-mode increment so dd can be clamped in the same edge.
  days_in_month u_dim_run (
    .month (month_q),
    .yyyy  (yyyy_q),
    .days  (run_days)
  );

  days_in_month u_dim_clamp (
    .month (clamp_month),
    .yyyy  (clamp_year),
    .days  (clamp_days)
  );

  assign tick        = (state_q == ST_RUN) && (sec_cnt_q == SEC_LAST);
  assign inc_month   = (month_q == MAX_MONTH) ? MONTH_RST : month_q + 4'd1;
  assign inc_year    = (yyyy_q == MAX_YEAR) ? 14'd0 : yyyy_q + 14'd1;
  assign next_dd     = (dd_q >= run_days) ? DAY_RST : dd_q + 5'd1;
  assign clamp_month = (state_q == ST_SET_MID) ? inc_month : month_q;
  assign clamp_year  = (state_q == ST_SET_HI) ? inc_year : yyyy_q;
  assign clamped_dd  = (dd_q > clamp_days) ? clamp_days : dd_q;

  always_comb begin
    state_d     = state_q;
    sec_cnt_d   = sec_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    dsel_d      = dsel_q;
    ss_d        = ss_q;
    mm_d        = mm_q;
    hh_d        = hh_q;
    dd_d        = dd_q;
    month_d     = month_q;
    yyyy_d      = yyyy_q;

    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end

    // Prescaler sits at 0 throughout set mode, so leaving SET_HI restarts cleanly.
    if ((state_q != ST_RUN) || btn_set || tick) sec_cnt_d = '0;
    else                                       sec_cnt_d = sec_cnt_q + SEC_W'(1);

    if (tick) begin
      ss_d = (ss_q == MAX_SEC) ? 6'd0 : ss_q + 6'd1;
      if (ss_q == MAX_SEC) begin
        mm_d = (mm_q == MAX_MIN) ? 6'd0 : mm_q + 6'd1;
        if (mm_q == MAX_MIN) begin
          hh_d = (hh_q == MAX_HOUR) ? 5'd0 : hh_q + 5'd1;
          if (hh_q == MAX_HOUR) begin
            dd_d = next_dd;
            if (dd_q >= run_days) begin
              month_d = inc_month;
              if (month_q == MAX_MONTH) yyyy_d = inc_year;
            end
          end
        end
      end
    end

    if (btn_set) begin
      state_d = state_e'(state_q + 2'd1);
    end else if (btn_mode) begin
      dsel_d = ~dsel_q;
    end else if (btn_inc && (state_q != ST_RUN)) begin
      case ({dsel_q, state_q})
        3'b001: ss_d = (ss_q == MAX_SEC) ? 6'd0 : ss_q + 6'd1;
        3'b010: mm_d = (mm_q == MAX_MIN) ? 6'd0 : mm_q + 6'd1;
        3'b011: hh_d = (hh_q == MAX_HOUR) ? 5'd0 : hh_q + 5'd1;
        3'b101: dd_d = next_dd;
        3'b110: begin
          month_d = inc_month;
          dd_d    = clamped_dd;
        end
        3'b111: begin
          yyyy_d = inc_year;
          dd_d   = clamped_dd;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      sec_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      dsel_q      <= 1'b0;
      ss_q        <= 6'd0;
      mm_q        <= 6'd0;
      hh_q        <= 5'd0;
      dd_q        <= DAY_RST;
      month_q     <= MONTH_RST;
      yyyy_q      <= YEAR_RST;
    end else begin
      state_q     <= state_d;
      sec_cnt_q   <= sec_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      dsel_q      <= dsel_d;
      ss_q        <= ss_d;
      mm_q        <= mm_d;
      hh_q        <= hh_d;
      dd_q        <= dd_d;
      month_q     <= month_d;
      yyyy_q      <= yyyy_d;
    end
  end

  assign ss          = ss_q;
  assign mm          = mm_q;
  assign hh          = hh_q;
  assign dd          = dd_q;
  assign month       = month_q;
  assign yyyy        = yyyy_q;
  assign blink2Hz    = blink_q;
  assign set_mode    = (state_q != ST_RUN);
  assign field_sel   = state_q;
  assign display_sel = dsel_q;
  assign mode        = dsel_q;

endmodule

// File: tb/tb_time_date_keeper.sv
// Scoreboard bench for time_date_keeper at CLK_HZ = 8: a behavioural model
// queues expected outputs per driven cycle; directed checks cover rollovers.
module tb_time_date_keeper;

  localparam int CLK_HZ = 8;

  logic        clk = 1'b0;
  logic        rst, btn_mode, btn_set, btn_inc;
  logic [5:0]  ss, mm;
  logic [4:0]  hh, dd;
  logic [3:0]  month;
  logic [13:0] yyyy;
  logic        blink2Hz, set_mode, display_sel, mode;
  logic [1:0]  field_sel;

  always #5 clk = ~clk;

  time_date_keeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_set(btn_set), .btn_inc(btn_inc),
    .ss(ss), .mm(mm), .hh(hh), .dd(dd), .month(month), .yyyy(yyyy),
    .blink2Hz(blink2Hz), .set_mode(set_mode), .field_sel(field_sel),
    .display_sel(display_sel), .mode(mode)
  );

  typedef struct {
    logic [16:0] t;
    logic [22:0] d;
    logic [5:0]  c;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  int m_ss, m_mm, m_hh, m_dd, m_mon, m_yr, m_st, m_pre, m_bc, m_blink, m_dsel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int dim_f(input int mo, input int y);
    bit leap;
`ifdef TIME_DATE_LEAP_YEAR_EN
    leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
`else
    leap = 1'b0;
`endif
    if (mo == 2) return leap ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit md, input bit in);
    bit tk;
    int sel;
    if (r) begin
      m_ss = 0; m_mm = 0; m_hh = 0; m_dd = 1; m_mon = 1; m_yr = 2000;
      m_st = 0; m_pre = 0; m_bc = 0; m_blink = 0; m_dsel = 0;
      return;
    end
    tk = (m_st == 0) && (m_pre == CLK_HZ - 1);
    if (m_bc == CLK_HZ / 4 - 1) begin m_bc = 0; m_blink ^= 1; end
    else m_bc++;
    if (m_st != 0 || s) m_pre = 0;
    else m_pre = (m_pre + 1) % CLK_HZ;
    if (tk) begin
      m_ss = (m_ss + 1) % 60;
      if (m_ss == 0) begin
        m_mm = (m_mm + 1) % 60;
        if (m_mm == 0) begin
          m_hh = (m_hh + 1) % 24;
          if (m_hh == 0) begin
            m_dd = m_dd % dim_f(m_mon, m_yr) + 1;
            if (m_dd == 1) begin
              m_mon = m_mon % 12 + 1;
              if (m_mon == 1) m_yr = (m_yr + 1) % 10000;
            end
          end
        end
      end
    end
    if (s) m_st = (m_st + 1) % 4;
    else if (md) m_dsel ^= 1;
    else if (in && m_st != 0) begin
      sel = m_dsel * 4 + m_st;
      if (sel == 1) m_ss = (m_ss + 1) % 60;
      if (sel == 2) m_mm = (m_mm + 1) % 60;
      if (sel == 3) m_hh = (m_hh + 1) % 24;
      if (sel == 5) m_dd = m_dd % dim_f(m_mon, m_yr) + 1;
      if (sel == 6) m_mon = m_mon % 12 + 1;
      if (sel == 7) m_yr = (m_yr + 1) % 10000;
      if ((sel == 6 || sel == 7) && m_dd > dim_f(m_mon, m_yr)) m_dd = dim_f(m_mon, m_yr);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit md, input bit in);
    exp_t e;
    rst = r; btn_set = s; btn_mode = md; btn_inc = in;
    model_step(r, s, md, in);
    e.t = {5'(m_hh), 6'(m_mm), 6'(m_ss)};
    e.d = {14'(m_yr), 4'(m_mon), 5'(m_dd)};
    e.c = {1'(m_blink), 1'(m_st != 0), 2'(m_st), 1'(m_dsel), 1'(m_dsel)};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_time", 32'({hh, mm, ss}), 32'(e.t));
    check("sb_date", 32'({yyyy, month, dd}), 32'(e.d));
    check("sb_ctl", 32'({blink2Hz, set_mode, field_sel, display_sel, mode}), 32'(e.c));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  function automatic int mfield(input int f);
    case (f)
      1: return m_ss;
      2: return m_mm;
      3: return m_hh;
      5: return m_dd;
      6: return m_mon;
      7: return m_yr;
      default: return -1;
    endcase
  endfunction

  task automatic go_state(input int st, input int dsel);
    if (m_dsel != dsel) cyc(0, 0, 1, 0);
    for (int g = 0; g < 4 && m_st != st; g++) cyc(0, 1, 0, 0);
  endtask

  task automatic set_field(input int dsel, input int st, input int v);
    int guard = 0;
    go_state(st, dsel);
    while (mfield(dsel * 4 + st) != v && guard < 12000) begin
      cyc(0, 0, 0, 1);
      guard++;
    end
    if (guard >= 12000) check("inc_guard", 32'(mfield(dsel * 4 + st)), 32'(v));
  endtask

  // Month and year go first so their clamp cannot disturb the day set afterwards.
  task automatic set_datetime(input int h, input int mi, input int s, input int d,
                              input int mo, input int y);
    set_field(1, 2, mo);
    set_field(1, 3, y);
    set_field(1, 1, d);
    set_field(0, 1, s);
    set_field(0, 2, mi);
    set_field(0, 3, h);
    cyc(0, 1, 0, 0);
  endtask

  initial begin
    int s0;
    rst = 1'b1; btn_mode = 1'b0; btn_set = 1'b0; btn_inc = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rst_time", 32'({hh, mm, ss}), 32'd0);
    check("rst_date", 32'({yyyy, month, dd}), 32'({14'd2000, 4'd1, 5'd1}));
    check("rst_ctl", 32'({blink2Hz, set_mode, field_sel, display_sel, mode}), 32'd0);

    idle(7);
    check("ss_before_tick", 32'(ss), 32'd0);
    idle(1);
    check("first_tick", 32'(ss), 32'd1);
    idle(13);

    s0 = m_ss;
    cyc(0, 1, 0, 1);
    check("set_inc_ctl", 32'({set_mode, field_sel}), 32'(3'b101));
    check("set_inc_ss", 32'(ss), 32'(s0));
    idle(16);
    check("frozen_ss", 32'(ss), 32'(s0));
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    go_state(0, 0);

    set_datetime(23, 59, 59, 31, 12, 2023);
    idle(7);
    check("pre_roll_time", 32'({hh, mm, ss}), 32'({5'd23, 6'd59, 6'd59}));
    idle(1);
    check("roll_time", 32'({hh, mm, ss}), 32'd0);
    check("roll_date", 32'({yyyy, month, dd}), 32'({14'd2024, 4'd1, 5'd1}));

    set_datetime(23, 59, 59, 28, 2, 2024);
    idle(8);
`ifdef TIME_DATE_LEAP_YEAR_EN
    check("feb28_2024", 32'({yyyy, month, dd}), 32'({14'd2024, 4'd2, 5'd29}));
    set_field(0, 1, 59);
    set_field(0, 2, 59);
    set_field(0, 3, 23);
    cyc(0, 1, 0, 0);
    idle(8);
    check("feb29_2024", 32'({yyyy, month, dd}), 32'({14'd2024, 4'd3, 5'd1}));
`else
    check("feb28_2024", 32'({yyyy, month, dd}), 32'({14'd2024, 4'd3, 5'd1}));
`endif

    set_datetime(23, 59, 59, 28, 2, 1900);
    idle(8);
    check("feb28_1900", 32'({yyyy, month, dd}), 32'({14'd1900, 4'd3, 5'd1}));

    set_datetime(23, 59, 59, 28, 2, 2000);
    idle(8);
`ifdef TIME_DATE_LEAP_YEAR_EN
    check("feb28_2000", 32'({yyyy, month, dd}), 32'({14'd2000, 4'd2, 5'd29}));
`else
    check("feb28_2000", 32'({yyyy, month, dd}), 32'({14'd2000, 4'd3, 5'd1}));
`endif

    set_datetime(12, 0, 0, 31, 1, 2024);
    go_state(2, 1);
    cyc(0, 0, 0, 1);
`ifdef TIME_DATE_LEAP_YEAR_EN
    check("clamp_2024", 32'({month, dd}), 32'({4'd2, 5'd29}));
`else
    check("clamp_2024", 32'({month, dd}), 32'({4'd2, 5'd28}));
`endif
    go_state(3, 1);
    cyc(0, 0, 0, 1);
    check("clamp_2025", 32'({yyyy, month, dd}), 32'({14'd2025, 4'd2, 5'd28}));
    go_state(0, 0);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 30);

    set_field(1, 3, 2031);
    check("pre_rst_state", 32'({set_mode, field_sel, yyyy}), 32'({3'b111, 14'd2031}));
    cyc(1, 1, 1, 1);
    check("mid_rst_time", 32'({hh, mm, ss}), 32'd0);
    check("mid_rst_date", 32'({yyyy, month, dd}), 32'({14'd2000, 4'd1, 5'd1}));
    check("mid_rst_ctl", 32'({blink2Hz, set_mode, field_sel, display_sel, mode}), 32'd0);
    idle(8);
    check("post_rst_tick", 32'(ss), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
